// File: rtl/m9k_pkg.sv
// Shared definitions for the banked M9K memory: default parameters,
// controller state encoding and index-width helpers.
package m9k_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_NUM_PORTS = 2;

    // CLEAR sweeps zeros through every bank; IDLE serves requesters.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Width of the bank-select field taken from the low address bits.
    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    // Width of the per-bank row index (remaining upper address bits).
    function automatic int row_idx_w(input int addr_w, input int num_banks);
        return addr_w - $clog2(num_banks);
    endfunction

    // Width needed to name a requester port.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/m9k_bank.sv
// One single-port memory bank with write enable and registered read.
// The read register only updates on a read, so data survives until the
// response has been consumed even if the bank is written afterwards.
module m9k_bank #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ROW_W];
    logic [DATA_W-1:0] rdata_reg;

    // Single access per cycle: write, or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/m9k_banked_mem.sv
// Multi-port, low-order interleaved memory built from single-port banks.
// Each bank arbitrates its requesters round-robin; read data returns one
// cycle after acceptance on the requesting port. A clear engine zeroes
// the whole memory after reset and on request.
module m9k_banked_mem
    import m9k_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata,
    input  logic                        clear_start,
    output logic                        busy
);

    localparam int BANK_W = bank_idx_w(NUM_BANKS);
    localparam int ROW_W  = row_idx_w(ADDR_W, NUM_BANKS);
    localparam int PORT_W = port_idx_w(NUM_PORTS);
    localparam logic [ROW_W-1:0]  LAST_ROW = {ROW_W{1'b1}};
    localparam logic [PORT_W:0]   NP_L     = (PORT_W + 1)'(NUM_PORTS);

    state_t           state_reg, state_next;
    logic [ROW_W-1:0] clr_row_reg, clr_row_next;

    // Unpacked views of the flattened request buses.
    logic [BANK_W-1:0] port_bank  [NUM_PORTS];
    logic [ROW_W-1:0]  port_row   [NUM_PORTS];
    logic [DATA_W-1:0] port_wdata [NUM_PORTS];

    // Per-bank results shared with the response logic.
    logic [NUM_PORTS-1:0] grant        [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_rd_pend;
    logic [PORT_W-1:0]    bank_rd_port [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rdata   [NUM_BANKS];

    genvar gi;

    // Clear sequencing: sweep rows while in CLEAR, restart on clear_start.
    always_comb begin
        state_next   = state_reg;
        clr_row_next = clr_row_reg;
        case (state_reg)
            CLEAR: begin
                if (clr_row_reg == LAST_ROW) begin
                    state_next   = IDLE;
                    clr_row_next = '0;
                end else begin
                    clr_row_next = clr_row_reg + 1'b1;
                end
            end
            IDLE: begin
                if (clear_start) begin
                    state_next   = CLEAR;
                    clr_row_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_row_next = '0;
            end
        endcase
    end

    // Controller state and clear row counter.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg   <= CLEAR;
            clr_row_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_row_reg <= clr_row_next;
        end
    end

    assign busy = (state_reg == CLEAR);

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_decode
            assign port_bank[gi]  = req_addr[gi*ADDR_W +: BANK_W];
            assign port_row[gi]   = req_addr[gi*ADDR_W + BANK_W +: ROW_W];
            assign port_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end

        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [NUM_PORTS-1:0] bank_req;
            logic [PORT_W-1:0]    ptr_reg, ptr_next;
            logic [PORT_W-1:0]    win;
            logic                 win_found;
            logic                 do_grant;
            logic                 rd_pend_reg;
            logic [PORT_W-1:0]    rd_port_reg;
            logic                 ram_en, ram_we;
            logic [ROW_W-1:0]     ram_addr;
            logic [DATA_W-1:0]    ram_wdata;

            // Which ports are requesting this bank this cycle.
            always_comb begin
                bank_req = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    bank_req[p] = req_valid[p] && (port_bank[p] == BANK_W'(gi));
                end
            end

            // Round-robin pick: first requester at or after the pointer.
            // Scanning offsets from high to low leaves the nearest one.
            always_comb begin
                logic [PORT_W:0]   sum;
                logic [PORT_W-1:0] idx;
                win       = ptr_reg;
                win_found = 1'b0;
                sum       = '0;
                idx       = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    sum = {1'b0, ptr_reg} + (PORT_W + 1)'(i);
                    if (sum >= NP_L) begin
                        sum = sum - NP_L;
                    end
                    idx = sum[PORT_W-1:0];
                    if (bank_req[idx]) begin
                        win       = idx;
                        win_found = 1'b1;
                    end
                end
            end

            assign do_grant  = (state_reg == IDLE) && win_found;
            assign grant[gi] = do_grant ? (NUM_PORTS'(1) << win) : '0;

            // Pointer advances past the winner after every grant.
            always_comb begin
                ptr_next = ptr_reg;
                if (do_grant) begin
                    ptr_next = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
                end
            end

            // Bank port mux: the clear engine owns the bank during CLEAR.
            always_comb begin
                ram_en    = 1'b0;
                ram_we    = 1'b0;
                ram_addr  = '0;
                ram_wdata = '0;
                if (state_reg == CLEAR) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = clr_row_reg;
                end else if (win_found) begin
                    ram_en    = 1'b1;
                    ram_we    = req_we[win];
                    ram_addr  = port_row[win];
                    ram_wdata = port_wdata[win];
                end
            end

            // Arbitration pointer and the port id of the read in flight.
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    ptr_reg     <= '0;
                    rd_pend_reg <= 1'b0;
                    rd_port_reg <= '0;
                end else begin
                    ptr_reg     <= ptr_next;
                    rd_pend_reg <= do_grant && !req_we[win];
                    rd_port_reg <= win;
                end
            end

            assign bank_rd_pend[gi] = rd_pend_reg;
            assign bank_rd_port[gi] = rd_port_reg;

            m9k_bank #(
                .DATA_W (DATA_W),
                .ROW_W  (ROW_W)
            ) u_bank (
                .clk   (clk),
                .en    (ram_en),
                .we    (ram_we),
                .addr  (ram_addr),
                .wdata (ram_wdata),
                .rdata (bank_rdata[gi])
            );
        end

        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
            logic              hit;
            logic              ready_any;
            logic [DATA_W-1:0] data_mux;
            logic [DATA_W-1:0] hold_reg;

            // Find the bank (if any) returning read data to this port.
            always_comb begin
                hit       = 1'b0;
                data_mux  = '0;
                ready_any = 1'b0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (bank_rd_pend[b] && (bank_rd_port[b] == PORT_W'(gi))) begin
                        hit      = 1'b1;
                        data_mux = bank_rdata[b];
                    end
                    ready_any = ready_any | grant[b][gi];
                end
            end

            // Last delivered word, shown while no response is valid.
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    hold_reg <= '0;
                end else if (hit) begin
                    hold_reg <= data_mux;
                end
            end

            assign req_ready[gi]                  = ready_any;
            assign rsp_valid[gi]                  = hit;
            assign rsp_rdata[gi*DATA_W +: DATA_W] = hit ? data_mux : hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_m9k_banked_mem.sv
// Scoreboard bench for m9k_banked_mem: a driver issues requests and pushes
// expected read data from a word-level memory model; a monitor pops and
// compares whenever the DUT presents a response.
`timescale 1ns/1ps
module tb_m9k_banked_mem;

    localparam int DW = 32;
    localparam int AW = 15;
    localparam int NB = 4;
    localparam int NP = 2;
    localparam int CLEAR_CYC = (1 << AW) / NB;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l = 1'b1;
    logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_rdata;
    logic clear_start = 1'b0;
    logic busy;

    logic [NP-1:0] p_valid = '0;
    logic [NP-1:0] p_we = '0;
    logic [AW-1:0] p_addr  [NP];
    logic [DW-1:0] p_wdata [NP];
    logic [NP-1:0] acc_vec;

    logic [DW-1:0] model_mem [int];
    int            rr [NB];
    bit            model_idle = 1'b0;
    exp_t          exp_q [NP][$];
    logic [DW-1:0] last_exp [NP];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = p_valid;
        req_we    = p_we;
        for (int p = 0; p < NP; p++) begin
            req_addr[p*AW +: AW]  = p_addr[p];
            req_wdata[p*DW +: DW] = p_wdata[p];
        end
    end

    m9k_banked_mem #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_BANKS (NB),
        .NUM_PORTS (NP)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .clear_start (clear_start),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int a);
        return model_mem.exists(a) ? model_mem[a] : '0;
    endfunction

    // One clock of stimulus: check handshake/busy, account transfers in
    // the model, then release accepted requests after the edge.
    task automatic step();
        logic [NP-1:0] exp_ready;
        bit taken;
        int p;
        @(negedge clk);
        exp_ready = '0;
        if (model_idle) begin
            for (int b = 0; b < NB; b++) begin
                taken = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    p = (rr[b] + i) % NP;
                    if (!taken && p_valid[p] && (int'(p_addr[p]) % NB) == b) begin
                        exp_ready[p] = 1'b1;
                        taken = 1'b1;
                        rr[b] = (p + 1) % NP;
                    end
                end
            end
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(!model_idle));
        acc_vec = p_valid & req_ready;
        for (int q = 0; q < NP; q++) begin
            if (acc_vec[q]) begin
                $display("acc port=%0d we=%0d addr=%0d wdata=%h cyc=%0d",
                         q, p_we[q], p_addr[q], p_wdata[q], cyc);
                if (p_we[q]) begin
                    model_mem[int'(p_addr[q])] = p_wdata[q];
                end else begin
                    exp_q[q].push_back('{due: cyc + 1, data: model_rd(int'(p_addr[q]))});
                end
            end
        end
        if (clear_start && model_idle) begin
            model_mem.delete();
        end
        @(posedge clk);
        #1;
        p_valid     = p_valid & ~acc_vec;
        clear_start = 1'b0;
    endtask

    task automatic issue(input int p, input bit we, input int addr, input logic [DW-1:0] data);
        p_we[p]    = we;
        p_addr[p]  = AW'(addr);
        p_wdata[p] = data;
        p_valid[p] = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && p_valid != '0; i++) step();
        check("drain_timeout", 64'(p_valid), 64'd0);
        step();
        step();
    endtask

    task automatic expect_clear();
        model_idle = 1'b0;
        for (int i = 0; i < CLEAR_CYC; i++) step();
        model_idle = 1'b1;
    endtask

    task automatic assert_reset();
        rst_l       = 1'b0;
        p_valid     = '0;
        clear_start = 1'b0;
        model_idle  = 1'b0;
        model_mem.delete();
        for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            last_exp[p] = '0;
        end
        for (int b = 0; b < NB; b++) rr[b] = 0;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    // Response monitor: pop expected entries as responses appear.
    always @(negedge clk) begin
        exp_t e;
        if (rst_l) begin
            for (int p = 0; p < NP; p++) begin
                while (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
                    e = exp_q[p].pop_front();
                    check($sformatf("rsp_missing_p%0d", p), 64'(0), 64'(1));
                end
                if (rsp_valid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("rsp_unexpected_p%0d", p), 64'(1), 64'(0));
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("rsp_cycle_p%0d", p), 64'(cyc), 64'(e.due));
                        check($sformatf("rsp_data_p%0d", p), 64'(rsp_rdata[p*DW +: DW]), 64'(e.data));
                        $display("rsp port=%0d data=%h cyc=%0d", p, rsp_rdata[p*DW +: DW], cyc);
                        last_exp[p] = e.data;
                    end
                end else begin
                    check($sformatf("rsp_hold_p%0d", p), 64'(rsp_rdata[p*DW +: DW]), 64'(last_exp[p]));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            p_addr[p]  = '0;
            p_wdata[p] = '0;
        end
        #2;
        assert_reset();
        release_reset();

        // Requests held during the post-reset clear must not be granted.
        issue(0, 1'b0, 1, '0);
        issue(1, 1'b0, 5, '0);
        expect_clear();

        // Contention on bank 1: port0 first, port1 next cycle.
        step();
        check("contend_first", 64'(acc_vec), 64'b01);
        step();
        check("contend_second", 64'(acc_vec), 64'b10);
        drain();

        // Post-clear reads of the corner addresses; bank 0 and 3 in parallel.
        issue(0, 1'b0, 0, '0);
        issue(1, 1'b0, 32767, '0);
        step();
        check("parallel_edge", 64'(acc_vec), 64'b11);
        drain();

        // Write then immediate read-back.
        issue(0, 1'b1, 5, 32'hDEADBEEF);
        step();
        check("wr5_accept", 64'(acc_vec), 64'b01);
        issue(0, 1'b0, 5, '0);
        step();
        check("rd5_accept", 64'(acc_vec), 64'b01);
        drain();

        // Two different banks on the same cycle.
        issue(0, 1'b0, 0, '0);
        issue(1, 1'b0, 3, '0);
        step();
        check("diff_bank_accept", 64'(acc_vec), 64'b11);
        drain();

        // Randomized traffic, focused on a small window plus the top rows.
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_valid[p] && $urandom_range(0, 3) != 0) begin
                    issue(p, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0) ? 32767 - int'($urandom_range(0, 7))
                                                      : int'($urandom_range(0, 31)),
                          $urandom);
                end
            end
            step();
        end
        drain();

        // Clear with a read accepted on the same edge.
        issue(0, 1'b1, 9, 32'h12345678);
        step();
        issue(0, 1'b0, 9, '0);
        clear_start = 1'b1;
        step();
        check("clear_read_accept", 64'(acc_vec), 64'b01);
        expect_clear();
        for (int a = 0; a < 16; a++) begin
            issue(0, 1'b0, a, '0);
            issue(1, 1'b0, a + 16, '0);
            drain();
        end
        issue(0, 1'b0, 32767, '0);
        drain();

        // Reset in the middle of a read burst.
        for (int n = 0; n < 4; n++) begin
            issue(0, 1'b0, 4 * n + 1, '0);
            issue(1, 1'b0, 4 * n + 2, '0);
            step();
        end
        issue(0, 1'b0, 7, '0);
        issue(1, 1'b0, 2, '0);
        step();
        check("burst_rsp_before_rst", 64'(rsp_valid), 64'b11);
        assert_reset();
        #1;
        check("rsp_drop_on_rst", 64'(rsp_valid), 64'd0);
        release_reset();
        expect_clear();
        issue(0, 1'b0, 7, '0);
        drain();

        check("q0_empty", 64'(exp_q[0].size()), 64'd0);
        check("q1_empty", 64'(exp_q[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
